ethernet_rx: RTL and testbench
==============================

# ethernet_rx

Receive-side counterpart of the PHY transmit path. Samples the 4-bit MII-style nibble stream from the PHY, strips the 0x55 preamble and 0xD5 SFD, checks and drops the 12-byte MAC header, and reassembles the fixed-length payload into bytes for the downstream FIFO. Frames carry no type field and no FCS; payload length is fixed.

## Interface
- `PAYLOAD_LEN`, default 1350: payload bytes per frame.
- `LOCAL_MAC`, default 48'h309C231EEC21: expected destination MAC; bits [47:40] are the first byte on the wire.
- `PRE_MIN`, default 2: minimum count of 0x5 nibbles before 0xD to accept the SFD.
- `clk` in, 1: 25 MHz PHY receive clock; the only clock.
- `rst` in, 1: synchronous, active-high reset.
- `rx_ctrl` in, 1: PHY receive data valid.
- `phy_rxd` in, 4: PHY receive nibble; low nibble of each byte arrives first.
- `dataout` out, 8: assembled payload byte.
- `data_valid` out, 1: `dataout` valid for one cycle.
- `frame_done` out, 1: one-cycle pulse, asserted together with the last payload byte's `data_valid`.
- `frame_err` out, 1: one-cycle pulse when a frame is aborted (truncation, bad SFD, MAC mismatch).

## Operation
- States: IDLE, PREAMBLE, HEADER, DATA, DROP.
- IDLE: when `rx_ctrl`=1 and nibble=0x5, go to PREAMBLE with pre_cnt=1. Any other nibble with `rx_ctrl`=1 goes to DROP with no `frame_err`.
- PREAMBLE: each 0x5 increments pre_cnt, which saturates at 15.
  - 0xD with pre_cnt≥PRE_MIN: go to HEADER. Nibble phase=low, byte_cnt=0.
  - 0xD with pre_cnt<PRE_MIN, or any other nibble: go to DROP and pulse `frame_err`.
- Byte assembly in HEADER and DATA: the low nibble is held; on the high nibble, byte={high,low} and the phase toggles.
- HEADER: 12 bytes. Bytes 0–5 are compared against LOCAL_MAC in wire order. Bytes 6–11 (source MAC) are discarded. After byte 11, go to DATA with byte_cnt=0.
- DATA: each byte is output on `dataout`/`data_valid` and byte_cnt increments. When byte_cnt=PAYLOAD_LEN-1, assert `frame_done` with that byte, then go to DROP.
- DROP: ignore all nibbles. Go to IDLE when `rx_ctrl`=0.
- `rx_ctrl`=0 in PREAMBLE, HEADER or DATA: pulse `frame_err`, go to IDLE, and discard any half byte. No further `data_valid` is produced for that frame.
- byte_cnt is 11 bits; PAYLOAD_LEN ≤ 2047.

## Timing
- Reset values: `dataout`=0, `data_valid`=0, `frame_done`=0, `frame_err`=0. State=IDLE and all counters 0.
- `rst` mid-frame: IDLE on the next edge. The remainder of the frame is not treated as a new frame, because IDLE requires a 0x5 nibble to start.
- Inputs are used as sampled at posedge `clk`; there is no extra input register.
- Latency: `data_valid` is high in the cycle after the high nibble is sampled. Payload bytes arrive every 2 cycles.
- First payload `data_valid` comes 2 cycles after the last header nibble.
- `frame_err` pulses the cycle after the offending sample.
- `frame_done` and `frame_err` are never asserted together.
- `rx_ctrl` falling in the same cycle the last high nibble is sampled: the sample counts, so the frame completes with `frame_done` and no error.

## Configuration
- `ETH_RX_MAC_FILTER_EN` defined: a destination MAC mismatch is detected at the cycle header byte 5 completes. The block pulses `frame_err`, goes to DROP, and outputs no payload.
- Not defined: the destination MAC is not compared and every frame with a valid preamble/SFD is delivered. The comparator logic is absent.

## Structure
- Shared package `eth_pkg`:
  - state encoding for IDLE, PREAMBLE, HEADER, DATA, DROP;
  - `ETH_PRE_NIB`=4'h5 and `ETH_SFD_NIB`=4'hD;
  - `ETH_HDR_BYTES`=12;
  - default LOCAL_MAC and PAYLOAD_LEN, which the transmitter also uses.
- Sub-module `eth_nib2byte` handles nibble-phase tracking and byte assembly, with clear, nibble-valid and byte-valid signals. The FSM, counters and MAC compare stay in `ethernet_rx`.

## Test plan
- Nominal frame: 15×0x5, 0xD, a header with matching MAC, then payload nibbles forming 0x00..0xFF repeating. Expect 1350 `data_valid` pulses with correct bytes, `frame_done` on byte 1349, `frame_err` never.
- Truncation: `rx_ctrl` drops after payload byte 100's low nibble. Expect exactly 100 bytes (0–99), one `frame_err` pulse, no `frame_done`, and state back in IDLE.
- MAC mismatch with the macro defined: destination 0xFFFFFFFFFFFF. Expect `frame_err` after header byte 5 and zero `data_valid`. Without the macro, the same frame delivers 1350 bytes.
- Bad SFD: 0x5,0x5,0x7. Expect `frame_err` and nothing output. A following valid frame after `rx_ctrl` goes low is received correctly.
- Short preamble: a single 0x5 then 0xD with PRE_MIN=2. Expect `frame_err` and no data.
- Reset mid-payload: assert `rst` at byte 500. All outputs are 0 the next cycle, no further bytes come from that frame, and the next frame is received fully.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet PHY-path definitions: FSM encoding, framing nibbles and
// the default station MAC / payload length used by both rx and tx.
package eth_pkg;

  typedef logic [2:0] eth_state_t;

  localparam eth_state_t ST_IDLE     = 3'd0;
  localparam eth_state_t ST_PREAMBLE = 3'd1;
  localparam eth_state_t ST_HEADER   = 3'd2;
  localparam eth_state_t ST_DATA     = 3'd3;
  localparam eth_state_t ST_DROP     = 3'd4;

  localparam logic [3:0] ETH_PRE_NIB = 4'h5;
  localparam logic [3:0] ETH_SFD_NIB = 4'hD;

  localparam int ETH_HDR_BYTES   = 12;
  localparam int ETH_PAYLOAD_LEN = 1350;

  localparam logic [47:0] ETH_LOCAL_MAC = 48'h309C231EEC21;

  // Byte idx of a MAC in wire order (idx 0 is bits [47:40]).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [47:0] shifted;
    shifted = mac << {idx, 3'b000};
    return shifted[47:40];
  endfunction

endpackage

// File: rtl/eth_nib2byte.sv
// Nibble-to-byte assembler: holds the low nibble, emits {high,low} when the
// high nibble arrives. clear forces the phase back to "expecting low".
module eth_nib2byte (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       nib_valid,
  input  logic [3:0] nib,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  logic       phase_q, phase_d;
  logic [3:0] low_q, low_d;

  assign byte_data = {nib, low_q};

  always_comb begin
    phase_d    = phase_q;
    low_d      = low_q;
    byte_valid = 1'b0;
    if (clear) begin
      phase_d = 1'b0;
      low_d   = 4'h0;
    end else if (nib_valid) begin
      if (!phase_q) begin
        low_d   = nib;
        phase_d = 1'b1;
      end else begin
        phase_d    = 1'b0;
        byte_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      low_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

endmodule

// File: rtl/ethernet_rx.sv
// MII nibble receiver: strips preamble/SFD and the 12-byte MAC header, then
// streams the fixed-length payload. Define ETH_RX_MAC_FILTER_EN to drop
// frames whose destination MAC differs from LOCAL_MAC.
module ethernet_rx
  import eth_pkg::*;
#(
  parameter int          PAYLOAD_LEN = ETH_PAYLOAD_LEN,
  parameter logic [47:0] LOCAL_MAC   = ETH_LOCAL_MAC,
  parameter int          PRE_MIN     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_ctrl,
  input  logic [3:0] phy_rxd,
  output logic [7:0] dataout,
  output logic       data_valid,
  output logic       frame_done,
  output logic       frame_err
);

  localparam logic [10:0] LAST_IDX  = 11'(PAYLOAD_LEN - 1);
  localparam logic [10:0] HDR_LAST  = 11'(ETH_HDR_BYTES - 1);
  localparam logic [3:0]  PRE_MIN_L = 4'(PRE_MIN);

  eth_state_t  state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  dataout_q, dataout_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;

  logic        in_frame;
  logic        nib_clear;
  logic        nib_valid;
  logic        byte_valid;
  logic [7:0]  byte_data;

  // The assembler only runs inside HEADER/DATA; everywhere else it is held
  // cleared so a new frame always starts on a low nibble.
  assign in_frame  = (state_q == ST_HEADER) || (state_q == ST_DATA);
  assign nib_clear = !in_frame;
  assign nib_valid = in_frame && rx_ctrl;

  eth_nib2byte u_nib2byte (
    .clk        (clk),
    .rst        (rst),
    .clear      (nib_clear),
    .nib_valid  (nib_valid),
    .nib        (phy_rxd),
    .byte_valid (byte_valid),
    .byte_data  (byte_data)
  );

`ifdef ETH_RX_MAC_FILTER_EN
  logic mac_bad_q, mac_bad_d;
  logic byte_mismatch;

  assign byte_mismatch = (byte_data != mac_byte(LOCAL_MAC, byte_cnt_q[2:0]));
`endif

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    dataout_d    = dataout_q;
    data_valid_d = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef ETH_RX_MAC_FILTER_EN
    mac_bad_d    = mac_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_ctrl) begin
          if (phy_rxd == ETH_PRE_NIB) begin
            state_d   = ST_PREAMBLE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!rx_ctrl) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (phy_rxd == ETH_PRE_NIB) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if ((phy_rxd == ETH_SFD_NIB) && (pre_cnt_q >= PRE_MIN_L)) begin
          state_d    = ST_HEADER;
          byte_cnt_d = '0;
`ifdef ETH_RX_MAC_FILTER_EN
          mac_bad_d  = 1'b0;
`endif
        end else begin
          state_d     = ST_DROP;
          frame_err_d = 1'b1;
        end
      end
      ST_HEADER: begin
        if (!rx_ctrl) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (byte_valid) begin
          byte_cnt_d = byte_cnt_q + 11'd1;
`ifdef ETH_RX_MAC_FILTER_EN
          if (byte_cnt_q < 11'd6) mac_bad_d = mac_bad_q | byte_mismatch;
          // Verdict is due on the last destination byte, not at end of header.
          if ((byte_cnt_q == 11'd5) && (mac_bad_q || byte_mismatch)) begin
            state_d     = ST_DROP;
            frame_err_d = 1'b1;
          end else
`endif
          if (byte_cnt_q == HDR_LAST) begin
            state_d    = ST_DATA;
            byte_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (!rx_ctrl) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (byte_valid) begin
          dataout_d    = byte_data;
          data_valid_d = 1'b1;
          byte_cnt_d   = byte_cnt_q + 11'd1;
          if (byte_cnt_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (!rx_ctrl) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pre_cnt_q    <= 4'd0;
      byte_cnt_q   <= 11'd0;
      dataout_q    <= 8'h00;
      data_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      dataout_q    <= dataout_d;
      data_valid_q <= data_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef ETH_RX_MAC_FILTER_EN
  always_ff @(posedge clk) begin
    if (rst) mac_bad_q <= 1'b0;
    else     mac_bad_q <= mac_bad_d;
  end
`endif

  assign dataout    = dataout_q;
  assign data_valid = data_valid_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ethernet_rx.sv
// Bench for ethernet_rx: builds a whole nibble stream up front, derives the
// expected per-cycle outputs with a frame-level parser, then replays and compares.
module tb_ethernet_rx;

  localparam int          PAYLOAD_LEN = 1350;
  localparam logic [47:0] MAC         = 48'h309C231EEC21;
  localparam int          PRE_MIN     = 2;
`ifdef ETH_RX_MAC_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_ctrl;
  logic [3:0] phy_rxd;
  logic [7:0] dataout;
  logic       data_valid;
  logic       frame_done;
  logic       frame_err;

  always #20 clk = ~clk;

  ethernet_rx #(
    .PAYLOAD_LEN (PAYLOAD_LEN),
    .LOCAL_MAC   (MAC),
    .PRE_MIN     (PRE_MIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ctrl    (rx_ctrl),
    .phy_rxd    (phy_rxd),
    .dataout    (dataout),
    .data_valid (data_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  bit         s_rst[$];
  bit         s_ctrl[$];
  logic [3:0] s_nib[$];
  bit         e_valid[$];
  bit         e_done[$];
  bit         e_err[$];
  logic [7:0] e_data[$];

  int vectors     = 0;
  int miscompares = 0;
  int seg_start[8];
  int seg_valid[8];
  int seg_done[8];
  int seg_err[8];
  int first_valid0 = -1;

  task automatic push(input bit r, input bit c, input logic [3:0] n);
    s_rst.push_back(r);
    s_ctrl.push_back(c);
    s_nib.push_back(n);
  endtask

  task automatic push_gap(input int len);
    repeat (len) push(1'b0, 1'b0, 4'($urandom_range(0, 15)));
  endtask

  // Preamble of pre_len 0x5s, the given SFD nibble, header, payload.
  // Stops before nibble cut_nib (counted after the SFD); asserts rst on rst_nib.
  task automatic build_frame(input int pre_len, input logic [3:0] sfd, input logic [47:0] dest,
                             input bit rand_pay, input int cut_nib, input int rst_nib);
    logic [7:0]  b;
    logic [47:0] src;
    int          idx;
    for (int p = 0; p < pre_len; p++) push(1'b0, 1'b1, 4'h5);
    push(1'b0, 1'b1, sfd);
    src = {$urandom, 16'($urandom)};
    idx = 0;
    for (int k = 0; k < 12 + PAYLOAD_LEN; k++) begin
      if (k < 6)       b = 8'(dest >> (8 * (5 - k)));
      else if (k < 12) b = 8'(src >> (8 * (11 - k)));
      else             b = rand_pay ? 8'($urandom) : 8'(k - 12);
      for (int h = 0; h < 2; h++) begin
        if (idx == cut_nib) return;
        push(idx == rst_nib, 1'b1, (h == 0) ? b[3:0] : b[7:4]);
        idx++;
      end
    end
  endtask

  function automatic int skip_drop(input int j);
    int n = s_ctrl.size();
    while (j < n && !s_rst[j] && s_ctrl[j]) j++;
    return j;
  endfunction

  // Frame-level reference: walk the stream frame by frame and record which
  // sample each output event must follow.
  task automatic run_model();
    int          n, i, j, k, h, b, cnt, hdr, nxt;
    logic [7:0]  byt;
    logic [47:0] destv;
    n = s_ctrl.size();
    for (int t = 0; t < n; t++) begin
      e_valid.push_back(1'b0);
      e_done.push_back(1'b0);
      e_err.push_back(1'b0);
      e_data.push_back(8'h00);
    end
    i = 0;
    while (i < n) begin
      if (s_rst[i] || !s_ctrl[i]) begin
        i++;
      end else if (s_nib[i] != 4'h5) begin
        i = skip_drop(i + 1);
      end else begin
        cnt = 1; j = i + 1; hdr = -1; nxt = -1;
        while (nxt < 0 && hdr < 0) begin
          if (j >= n) nxt = n;
          else if (s_rst[j]) nxt = j;
          else if (!s_ctrl[j]) begin e_err[j] = 1'b1; nxt = j + 1; end
          else if (s_nib[j] == 4'h5) begin if (cnt < 15) cnt++; j++; end
          else if (s_nib[j] == 4'hD && cnt >= PRE_MIN) hdr = j + 1;
          else begin e_err[j] = 1'b1; nxt = skip_drop(j + 1); end
        end
        if (hdr >= 0) begin
          b = 0; k = hdr; destv = '0;
          while (nxt < 0) begin
            if (k >= n) nxt = n;
            else if (s_rst[k]) nxt = k;
            else if (!s_ctrl[k]) begin e_err[k] = 1'b1; nxt = k + 1; end
            else if (k + 1 >= n) nxt = n;
            else if (s_rst[k+1]) nxt = k + 1;
            else if (!s_ctrl[k+1]) begin e_err[k+1] = 1'b1; nxt = k + 2; end
            else begin
              byt = {s_nib[k+1], s_nib[k]};
              h = k + 1;
              if (b < 12) begin
                if (b < 6) destv = {destv[39:0], byt};
                if (FILTER && b == 5 && destv != MAC) begin
                  e_err[h] = 1'b1;
                  nxt = skip_drop(h + 1);
                end
              end else begin
                e_valid[h] = 1'b1;
                e_data[h]  = byt;
                if (b - 12 == PAYLOAD_LEN - 1) begin
                  e_done[h] = 1'b1;
                  nxt = skip_drop(h + 1);
                end
              end
              b++;
              k += 2;
            end
          end
        end
        i = nxt;
      end
    end
  endtask

  task automatic check_val(input string name, input int idx, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at sample %0d: got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic applyStimulus(input int i);
    rst     = s_rst[i];
    rx_ctrl = s_ctrl[i];
    phy_rxd = s_nib[i];
  endtask

  task automatic checkOutput(input int i);
    int seg = 0;
    check_val("data_valid", i, int'(data_valid), int'(e_valid[i]));
    check_val("frame_done", i, int'(frame_done), int'(e_done[i]));
    check_val("frame_err",  i, int'(frame_err),  int'(e_err[i]));
    if (e_valid[i] || s_rst[i]) check_val("dataout", i, int'(dataout), int'(e_data[i]));
    for (int k = 0; k < 7; k++) if (i >= seg_start[k]) seg = k;
    seg_valid[seg] += int'(data_valid);
    seg_done[seg]  += int'(frame_done);
    seg_err[seg]   += int'(frame_err);
    if (seg == 0 && data_valid && first_valid0 < 0) first_valid0 = i;
  endtask

  initial begin
    logic [3:0]  sfd;
    logic [47:0] dest;
    int          cut, rnib;

    // Reset, including a reset sample while rx_ctrl and a 0x5 are present.
    repeat (3) push(1'b1, 1'b0, 4'h0);
    push(1'b1, 1'b1, 4'h5);
    push_gap(2);

    seg_start[0] = s_ctrl.size();
    build_frame(15, 4'hD, MAC, 1'b0, -1, -1);
    push_gap(4);

    seg_start[1] = s_ctrl.size();
    build_frame(15, 4'hD, MAC, 1'b0, 225, -1);
    push_gap(4);

    seg_start[2] = s_ctrl.size();
    build_frame(15, 4'hD, 48'hFFFFFFFFFFFF, 1'b0, -1, -1);
    push_gap(4);

    seg_start[3] = s_ctrl.size();
    build_frame(2, 4'h7, MAC, 1'b0, 6, -1);
    push_gap(3);
    build_frame(15, 4'hD, MAC, 1'b1, -1, -1);
    push_gap(4);

    seg_start[4] = s_ctrl.size();
    build_frame(1, 4'hD, MAC, 1'b0, 8, -1);
    push_gap(4);

    seg_start[5] = s_ctrl.size();
    build_frame(15, 4'hD, MAC, 1'b0, -1, 1024);
    push_gap(4);
    build_frame(15, 4'hD, MAC, 1'b0, -1, -1);
    push_gap(4);

    seg_start[6] = s_ctrl.size();
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 4) == 0) push(1'b0, 1'b1, 4'($urandom_range(6, 15)));
      sfd  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'hD;
      dest = ($urandom_range(0, 3) == 0) ? {$urandom, 16'($urandom)} : MAC;
      cut  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 600));
      rnib = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 500)) : -1;
      build_frame(int'($urandom_range(1, 15)), sfd, dest, 1'b1, cut, rnib);
      push_gap(int'($urandom_range(1, 6)));
    end
    seg_start[7] = s_ctrl.size();

    run_model();

    rst = 1'b1; rx_ctrl = 1'b0; phy_rxd = 4'h0;
    for (int i = 0; i < s_ctrl.size(); i++) begin
      applyStimulus(i);
      @(posedge clk);
      #1;
      checkOutput(i);
    end

    // Hand-derived per-scenario totals that pin the reference itself.
    check_val("nominal_bytes", 0, seg_valid[0], PAYLOAD_LEN);
    check_val("nominal_done",  0, seg_done[0], 1);
    check_val("nominal_err",   0, seg_err[0], 0);
    check_val("nominal_first_valid", 0, first_valid0, seg_start[0] + 41);
    check_val("trunc_bytes", 1, seg_valid[1], 100);
    check_val("trunc_done",  1, seg_done[1], 0);
    check_val("trunc_err",   1, seg_err[1], 1);
    check_val("mac_bytes", 2, seg_valid[2], FILTER ? 0 : PAYLOAD_LEN);
    check_val("mac_done",  2, seg_done[2], FILTER ? 0 : 1);
    check_val("mac_err",   2, seg_err[2], FILTER ? 1 : 0);
    check_val("badsfd_bytes", 3, seg_valid[3], PAYLOAD_LEN);
    check_val("badsfd_done",  3, seg_done[3], 1);
    check_val("badsfd_err",   3, seg_err[3], 1);
    check_val("shortpre_bytes", 4, seg_valid[4], 0);
    check_val("shortpre_done",  4, seg_done[4], 0);
    check_val("shortpre_err",   4, seg_err[4], 1);
    check_val("rstmid_bytes", 5, seg_valid[5], 500 + PAYLOAD_LEN);
    check_val("rstmid_done",  5, seg_done[5], 1);
    check_val("rstmid_err",   5, seg_err[5], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
